seq_shift_add_mult: RTL

//  Parametrised sequential multiplier with its own datapath and FSM: shift-add, one multiplier bit per cycle.

---
 rtl/seq_shift_add_mult.sv | 91 +++++++++
 1 files changed

// File: rtl/seq_shift_add_mult.sv
// Sequential shift-add multiplier: one multiplier bit per cycle, signed/unsigned per operation,
// stops early once the remaining multiplier bits are zero. start/busy/done handshake.
module seq_shift_add_mult #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);
    localparam int PW = 2 * WIDTH;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, LOAD, CALC, FIN} state_t;

    state_t            state;
    logic [WIDTH-1:0]  a_r;
    logic [WIDTH-1:0]  b_r;
    logic              sm_r;
    logic [PW-1:0]     acc;
    logic [PW-1:0]     mcand;
    logic [WIDTH-1:0]  mplier;
    logic [CW-1:0]     cnt;
    logic              neg;

    // The most negative operand maps to 2^(WIDTH-1), which still fits as an unsigned magnitude.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] v, input logic sm);
        return (sm && v[WIDTH-1]) ? (~v + WIDTH'(1)) : v;
    endfunction

    function automatic logic [PW-1:0] apply_sign(input logic [PW-1:0] v, input logic n);
        return n ? (~v + PW'(1)) : v;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            sm_r    <= 1'b0;
            acc     <= '0;
            mcand   <= '0;
            mplier  <= '0;
            cnt     <= '0;
            neg     <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        a_r   <= a;
                        b_r   <= b;
                        sm_r  <= signed_mode;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    acc    <= '0;
                    mcand  <= {{WIDTH{1'b0}}, magnitude(a_r, sm_r)};
                    mplier <= magnitude(b_r, sm_r);
                    cnt    <= CW'(WIDTH);
                    neg    <= sm_r & (a_r[WIDTH-1] ^ b_r[WIDTH-1]);
                    state  <= CALC;
                end
                CALC: begin
                    // Early exit: no remaining multiplier bits can add anything.
                    if (mplier == '0 || cnt == '0) begin
                        product <= apply_sign(acc, neg);
                        state   <= FIN;
                    end else begin
                        if (mplier[0]) acc <= acc + mcand;
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end
                end
                FIN:     state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign busy = (state != IDLE);
    assign done = (state == FIN);

endmodule
